// File: rtl/clint_vec.sv
// rtl/clint_vec.sv - core-local interrupt controller: trap/MRET sequencing, optional vectored targets (CLINT_VECTOR_EN)
module clint_vec #(
    parameter int N_SRC      = 4,
    parameter int CAUSE_BASE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] src_en_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             div_started_i,
    input  logic [31:0]      csr_mtvec,
    input  logic [31:0]      csr_mepc,
    input  logic [31:0]      csr_mstatus,
    output logic             hold_flag_o,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      data_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o,
    output logic [N_SRC-1:0] int_ack_o
);

    localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INST_MRET    = 32'h3020_0073;
    localparam logic [31:0] CSR_MSTATUS  = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC     = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE   = 32'h0000_0342;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_MEPC    = 5'b00010,
        S_MSTATUS = 5'b00100,
        S_MCAUSE  = 5'b01000,
        S_MRET    = 5'b10000
    } state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SYNC,
        D_ASYNC,
        D_MRET
    } dec_t;

    state_t             r_state;
    state_t             w_state_nxt;
    dec_t               w_dec;
    logic               w_idle;
    logic               w_is_exc;
    logic [N_SRC-1:0]   w_pend;
    logic [3:0]         w_sel_idx;
    logic [31:0]        w_epc;
    logic [31:0]        w_cause;
    logic [31:0]        w_mst_trap;
    logic [31:0]        w_mst_mret;
    logic [31:0]        w_direct;
    logic [31:0]        w_target;
    logic [N_SRC-1:0]   w_ack;

    logic [31:0]        r_epc;
    logic [31:0]        r_cause;
    logic [3:0]         r_src_idx;
    logic               r_is_async;
    logic               r_we;
    logic [31:0]        r_waddr;
    logic [31:0]        r_data;
    logic               r_assert;
    logic [31:0]        r_addr;
    logic [N_SRC-1:0]   r_ack;

    // While in reset the machine is treated as idle so hold reflects only the inputs
    assign w_idle   = (r_state == S_IDLE) || !rst;
    assign w_is_exc = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    assign w_pend   = irq_i & src_en_i;

    // Lowest pending index wins; scanning downward leaves the lowest one last
    always_comb begin
        w_sel_idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel_idx = 4'(i);
            end
        end
    end

    // Event arbitration; an exception stalled behind the divider also masks interrupts
    always_comb begin
        w_dec = D_IDLE;
        if (w_idle) begin
            if (w_is_exc) begin
                if (!div_started_i) begin
                    w_dec = D_SYNC;
                end
            end else if ((|w_pend) && csr_mstatus[3]) begin
                w_dec = D_ASYNC;
            end else if (inst_i == INST_MRET) begin
                w_dec = D_MRET;
            end
        end
    end

    assign hold_flag_o = (w_dec != D_IDLE) || !w_idle;

    // Return address and cause captured when a trap is accepted
    always_comb begin
        w_epc   = inst_addr_i;
        w_cause = (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
        if (w_dec == D_ASYNC) begin
            w_cause = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(w_sel_idx));
            if (jump_flag_i) begin
                w_epc = jump_addr_i;
            end else if (div_started_i) begin
                w_epc = inst_addr_i - 32'd4;
            end
        end else if (jump_flag_i) begin
            w_epc = jump_addr_i - 32'd4;
        end
    end

    // Next CSR sequencing state
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_dec == D_SYNC || w_dec == D_ASYNC) begin
                    w_state_nxt = S_MEPC;
                end else if (w_dec == D_MRET) begin
                    w_state_nxt = S_MRET;
                end
            end
            S_MEPC:    w_state_nxt = S_MSTATUS;
            S_MSTATUS: w_state_nxt = S_MCAUSE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Trap context latched on acceptance so a dropping source cannot cancel it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_epc      <= 32'd0;
            r_cause    <= 32'd0;
            r_src_idx  <= 4'd0;
            r_is_async <= 1'b0;
        end else if (r_state == S_IDLE && (w_dec == D_SYNC || w_dec == D_ASYNC)) begin
            r_epc      <= w_epc;
            r_cause    <= w_cause;
            r_src_idx  <= w_sel_idx;
            r_is_async <= (w_dec == D_ASYNC);
        end
    end

    // mstatus images for trap entry (MPIE<-MIE, MIE<-0) and MRET (MIE<-MPIE, MPIE<-1)
    always_comb begin
        w_mst_trap    = csr_mstatus;
        w_mst_trap[7] = csr_mstatus[3];
        w_mst_trap[3] = 1'b0;
        w_mst_mret    = csr_mstatus;
        w_mst_mret[3] = csr_mstatus[7];
        w_mst_mret[7] = 1'b1;
    end

    assign w_direct = {csr_mtvec[31:2], 2'b00};
`ifdef CLINT_VECTOR_EN
    assign w_target = (r_is_async && csr_mtvec[1:0] == 2'b01)
                    ? w_direct + ((32'(CAUSE_BASE) + 32'(r_src_idx)) << 2)
                    : w_direct;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^csr_mtvec[1:0];
    assign w_target      = w_direct;
`endif

    // One-hot acknowledge of the latched source, only for interrupts
    always_comb begin
        w_ack = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_ack[i] = r_is_async && (r_src_idx == 4'(i));
        end
    end

    // Registered CSR writes and redirect, decoded from the sequencing state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_waddr  <= 32'd0;
            r_data   <= 32'd0;
            r_assert <= 1'b0;
            r_addr   <= 32'd0;
            r_ack    <= '0;
        end else begin
            r_we     <= 1'b0;
            r_waddr  <= 32'd0;
            r_data   <= 32'd0;
            r_assert <= 1'b0;
            r_addr   <= 32'd0;
            r_ack    <= '0;
            case (r_state)
                S_MEPC: begin
                    r_we    <= 1'b1;
                    r_waddr <= CSR_MEPC;
                    r_data  <= r_epc;
                end
                S_MSTATUS: begin
                    r_we    <= 1'b1;
                    r_waddr <= CSR_MSTATUS;
                    r_data  <= w_mst_trap;
                end
                S_MCAUSE: begin
                    r_we     <= 1'b1;
                    r_waddr  <= CSR_MCAUSE;
                    r_data   <= r_cause;
                    r_assert <= 1'b1;
                    r_addr   <= w_target;
                    r_ack    <= w_ack;
                end
                S_MRET: begin
                    r_we     <= 1'b1;
                    r_waddr  <= CSR_MSTATUS;
                    r_data   <= w_mst_mret;
                    r_assert <= 1'b1;
                    r_addr   <= csr_mepc;
                end
                default: begin
                end
            endcase
        end
    end

    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign data_o       = r_data;
    assign int_assert_o = r_assert;
    assign int_addr_o   = r_addr;
    assign int_ack_o    = r_ack;

endmodule

// File: doc/clint_vec.md
# clint_vec

Parametrised core-local interrupt controller for the RV32 core: arbitrates synchronous exceptions (ECALL/EBREAK), `N_SRC` level-sensitive external/timer interrupt sources with fixed priority, and MRET. Sits between decode/ex and csr_reg. Sequences the mepc/mstatus/mcause CSR writes, then issues a one-cycle redirect to ex. Acknowledges the taken source one-hot, and optionally computes RISC-V vectored trap targets.

## Interface
- `N_SRC`, 4: number of interrupt sources, 1..16; index 0 highest priority.
- `CAUSE_BASE`, 16: interrupt code of source 0; source i reports code `CAUSE_BASE+i`.
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-low.
- `irq_i` in N_SRC: level interrupt requests.
- `src_en_i` in N_SRC: per-source enable mask.
- `inst_i` in 32: instruction in decode.
- `inst_addr_i` in 32: its address.
- `jump_flag_i` in 1: ex is redirecting this cycle.
- `jump_addr_i` in 32: ex redirect target.
- `div_started_i` in 1: divider busy.
- `csr_mtvec` in 32: current mtvec.
- `csr_mepc` in 32: current mepc.
- `csr_mstatus` in 32: current mstatus. MIE is bit 3, MPIE is bit 7.
- `hold_flag_o` out 1: stall request to ctrl.
- `we_o` out 1: CSR write enable.
- `waddr_o` out 32: CSR write address (`{20'h0, csr}`).
- `data_o` out 32: CSR write data.
- `int_assert_o` out 1: redirect pulse to ex.
- `int_addr_o` out 32: redirect target.
- `int_ack_o` out N_SRC: one-hot acknowledge of the taken source, coincident with `int_assert_o`.

## Operation
- Combinational decision, evaluated only when `csr_state` is IDLE. The first matching rule wins:
  - SYNC: `inst_i` is ECALL or EBREAK and `div_started_i` is 0.
  - If ECALL/EBREAK is in decode and the divider is busy: IDLE. Async interrupts are also blocked that cycle.
  - ASYNC: `|(irq_i & src_en_i)` and `csr_mstatus[3]` is 1. The selected source is the lowest set index.
  - MRET: `inst_i` is MRET.
  - Otherwise IDLE.
- csr_state is one-hot: IDLE, MEPC, MSTATUS, MCAUSE, MRET.
  - IDLE goes to MEPC on SYNC or ASYNC, and to MRET on MRET.
  - MEPC → MSTATUS → MCAUSE → IDLE.
  - MRET → IDLE.
  - Illegal encodings go to IDLE.
- Registers captured on leaving IDLE: `epc`, `cause`, and `src_idx`.
- `epc` for SYNC: `jump_addr_i-4` if `jump_flag_i` is set, else `inst_addr_i`.
- `epc` for ASYNC, in priority order:
  - `jump_addr_i` if `jump_flag_i` is set;
  - else `inst_addr_i-4` if `div_started_i` is set;
  - else `inst_addr_i`.
- `cause`: ECALL gives 11 and EBREAK gives 3. ASYNC gives `32'h8000_0000 | (CAUSE_BASE+src_idx)`.
- A source dropping after capture does not cancel the sequence. Events arriving while not IDLE are ignored and must persist to be taken.
- CSR writes are registered from csr_state:
  - MEPC state: mepc ← `epc`.
  - MSTATUS state: mstatus ← csr_mstatus with bit 7 ← bit 3 and bit 3 ← 0.
  - MCAUSE state: mcause ← `cause`.
  - MRET state: mstatus ← csr_mstatus with bit 3 ← bit 7 and bit 7 ← 1.
  - All other states: `we_o`, `waddr_o` and `data_o` are 0.
- Redirect, registered:
  - MCAUSE state: `int_assert_o`=1, `int_addr_o`=trap target, and `int_ack_o`=one-hot(`src_idx`) for ASYNC, 0 for SYNC.
  - MRET state: `int_assert_o`=1 and `int_addr_o`=`csr_mepc`.
  - Otherwise all redirect outputs are 0.
- Direct trap target: `{csr_mtvec[31:2],2'b00}`.
- `hold_flag_o` = (decision ≠ IDLE) | (csr_state ≠ IDLE).

## Timing
- Reset values: `we_o`=0, `waddr_o`=0, `data_o`=0, `int_assert_o`=0, `int_addr_o`=0, `int_ack_o`=0. csr_state is IDLE; `epc`, `cause` and `src_idx` are 0.
- `hold_flag_o` depends only on inputs in reset.
- Trap taken at decision cycle T:
  - `hold_flag_o` is high during T..T+3.
  - mepc write is visible in T+2, mstatus in T+3, mcause in T+4.
  - `int_assert_o` pulses in T+4; `hold_flag_o` is low in T+4.
  - Total latency is 4 cycles.
- MRET at T: mstatus write and `int_assert_o` both in T+2; hold is high in T and T+1.
- Reset asserted mid-sequence: all outputs return to reset values at the next edge and no assert is issued.
- Back-to-back: a new decision is possible in T+4. By then MIE=0 (written at T+3), so async interrupts cannot nest.

## Configuration
- `CLINT_VECTOR_EN` defined:
  - If `csr_mtvec[1:0]`==2'b01 and the trap is ASYNC, target = `{mtvec[31:2],2'b00} + ((CAUSE_BASE+src_idx)<<2)`, 32-bit wrap.
  - SYNC traps and mode 00 use the direct target.
  - Mode values 10 and 11 behave as 00.
- Undefined: always the direct target; `mtvec[1:0]` is ignored.

## Test plan
- **ECALL:** `inst_i`=ECALL at `inst_addr_i`=0x100, `jump_flag_i`=0, `csr_mtvec`=0x200, mstatus=0x8 → required response:
  - mepc=0x100 in T+2;
  - mstatus=0x80 in T+3;
  - mcause=11 in T+4, with `int_assert_o`=1, `int_addr_o`=0x200 and `int_ack_o`=0.
- **Priority:** `irq_i`=4'b1010, `src_en_i`=4'b1111, MIE=1 → cause=0x80000011 and `int_ack_o`=4'b0010. With `src_en_i`=4'b1000 → cause=0x80000013.
- **Vectored:** with `CLINT_VECTOR_EN`, mtvec=0x1001 and source 2 → `int_addr_o`=0x1048. Without the macro → 0x1000.
- **Divider busy:** divider busy with ECALL in decode → no hold and no trap until `div_started_i`=0. Async with divider busy at `inst_addr_i`=0x40 → mepc=0x3C. Async with `jump_flag_i`=1 and `jump_addr_i`=0x80 → mepc=0x80.
- **MRET:** mstatus=0x80, `csr_mepc`=0x104 → mstatus=0x88 and `int_assert_o` with `int_addr_o`=0x104 in T+2. ECALL and `irq_i` together → the SYNC path is taken.
- **Reset and masking:** `rst`=0 in T+2 of a trap → no `int_assert_o` and all outputs 0. Interrupt with MIE=0 → no hold and no trap.
